// File: rtl/ssemi_cic_decimator.sv
// N-stage CIC (Hogenauer) decimator: integrators at the input rate, combs at fs/R,
// round-half-up scaling to OUT_WIDTH and a held valid/ready output register.
module ssemi_cic_decimator #(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int NUM_STAGES = 5,
    parameter int MAX_DECIM  = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic [$clog2(MAX_DECIM):0]    i_decim_ratio,
    input  logic signed [IN_WIDTH-1:0]    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic signed [OUT_WIDTH-1:0]   o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_overrun,
    output logic                          o_cfg_err,
    output logic                          o_busy
);
    localparam int CW    = $clog2(MAX_DECIM);
    localparam int RW    = CW + 1;
    localparam int W_INT = IN_WIDTH + NUM_STAGES * CW;
    localparam int SHIFT = W_INT - OUT_WIDTH;

    localparam logic [RW-1:0]           RATIO_MIN = RW'(2);
    localparam logic [RW-1:0]           RATIO_MAX = RW'(MAX_DECIM);
    localparam logic signed [W_INT-1:0] ROUND     = W_INT'(1) << (SHIFT - 1);

    logic signed [W_INT-1:0] integ    [NUM_STAGES];
    logic signed [W_INT-1:0] comb_dly [NUM_STAGES];
    logic signed [W_INT-1:0] comb_x   [NUM_STAGES];
    logic signed [W_INT-1:0] comb_out;
    logic signed [W_INT-1:0] rounded;
    logic signed [W_INT-1:0] scaled;

    logic [CW-1:0] count;
    logic [RW-1:0] ratio_q;
    logic [RW-1:0] ratio_clamped;
    logic [RW-1:0] ratio_eff;
    logic          ratio_bad;
    logic          cfg_loaded;
    logic          strobe;
    logic          accept;
    logic          last_sample;

    assign o_ready = i_enable;
    assign accept  = i_valid && i_enable;
    assign o_busy  = o_valid || strobe || (count != '0);

    // The ratio is not yet registered on the enabling cycle, so use the clamped port value then.
    always_comb begin
        ratio_bad     = (i_decim_ratio < RATIO_MIN) || (i_decim_ratio > RATIO_MAX);
        ratio_clamped = i_decim_ratio;
        if (i_decim_ratio < RATIO_MIN) begin
            ratio_clamped = RATIO_MIN;
        end else if (i_decim_ratio > RATIO_MAX) begin
            ratio_clamped = RATIO_MAX;
        end
        ratio_eff   = cfg_loaded ? ratio_q : ratio_clamped;
        last_sample = ({1'b0, count} == (ratio_eff - 1'b1));
    end

    // NOTE: blocking assignments are right inside always_comb; each stage reads the value the previous line just computed.
    always_comb begin
        comb_out = integ[NUM_STAGES-1];
        for (int k = 0; k < NUM_STAGES; k++) begin
            comb_x[k] = comb_out;
            comb_out  = comb_out - comb_dly[k];
        end
        rounded = comb_out + ROUND;
        scaled  = rounded >>> SHIFT;
    end

    // NOTE: the stage arrays are small register files, not RAM, so clearing them on reset is cheap and required.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                integ[k]    <= '0;
                comb_dly[k] <= '0;
            end
            count      <= '0;
            ratio_q    <= RATIO_MIN;
            cfg_loaded <= 1'b0;
            strobe     <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_overrun  <= 1'b0;
            o_cfg_err  <= 1'b0;
        end else if (!i_enable) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                integ[k]    <= '0;
                comb_dly[k] <= '0;
            end
            count      <= '0;
            ratio_q    <= RATIO_MIN;
            cfg_loaded <= 1'b0;
            strobe     <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_overrun  <= 1'b0;
            o_cfg_err  <= 1'b0;
        end else begin
            if (!cfg_loaded) begin
                cfg_loaded <= 1'b1;
                ratio_q    <= ratio_clamped;
                o_cfg_err  <= ratio_bad;
            end

            strobe <= accept && last_sample;

            // Every stage updates from pre-edge values; only stage 0 sees the new sample.
            if (accept) begin
                integ[0] <= integ[0] + W_INT'(i_data);
                for (int k = 1; k < NUM_STAGES; k++) begin
                    integ[k] <= integ[k] + integ[k-1];
                end
                count <= last_sample ? '0 : count + 1'b1;
            end

            if (strobe) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    comb_dly[k] <= comb_x[k];
                end
                o_data  <= scaled[OUT_WIDTH-1:0];
                o_valid <= 1'b1;
                if (o_valid && !i_ready) begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ssemi_cic_decimator.sv
// Directed bench for ssemi_cic_decimator: a table of DC streams with hand-derived
// step responses, plus sequences for reset, clamping, backpressure and full scale.
module tb_ssemi_cic_decimator;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [6:0]         decim_ratio;
    logic signed [15:0] data;
    logic               valid;
    logic               ready_out;
    logic signed [31:0] out_data;
    logic               out_valid;
    logic               ready_in;
    logic               overrun;
    logic               cfg_err;
    logic               busy;

    int      n_checks = 0;
    int      n_fail   = 0;
    int      cyc      = 0;
    int      first_valid_cyc;
    int      rth_acc_cyc;
    longint  got[$];

    typedef struct {
        logic [6:0]         ratio;
        logic signed [15:0] din;
        bit                 gapped;
        int                 n_out;
        longint             exp[8];
        logic [7:0]         mask;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    ssemi_cic_decimator dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_decim_ratio (decim_ratio),
        .i_data        (data),
        .i_valid       (valid),
        .o_ready       (ready_out),
        .o_data        (out_data),
        .o_valid       (out_valid),
        .i_ready       (ready_in),
        .o_overrun     (overrun),
        .o_cfg_err     (cfg_err),
        .o_busy        (busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sample();
        if (out_valid) begin
            got.push_back(out_data);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
    endtask

    task automatic start(input logic [6:0] r);
        valid  = 1'b0;
        enable = 1'b0;
        tick();
        decim_ratio = r;
        enable      = 1'b1;
    endtask

    // Presents n_acc samples of value d; the R-th accept's presenting cycle is remembered for the latency check.
    task automatic stream(input int n_acc, input int r, input logic signed [15:0] d, input bit gapped);
        int acc   = 0;
        int guard = 0;
        got.delete();
        first_valid_cyc = -1;
        rth_acc_cyc     = -1;
        data = d;
        while (acc < n_acc && guard < 4000) begin
            valid = gapped ? ((guard % 2) == 0) : 1'b1;
            tick();
            guard++;
            if (valid) begin
                acc++;
                if (acc == r) rth_acc_cyc = cyc - 1;
            end
            sample();
        end
        valid = 1'b0;
        repeat (4) begin
            tick();
            sample();
        end
        if (acc < n_acc) check("stream_timeout", acc, n_acc);
        if (got.size() > 0) check("latency", first_valid_cyc - rth_acc_cyc, 2);
    endtask

    initial begin
        // R-sample step responses of (1-z^-R)^5/(1-z^-1)^5 with the 4-sample integrator pipeline delay.
        vecs[0] = '{7'd4, 16'sd16384,  1'b0, 8, '{0, 56, 512, 968, 1024, 1024, 1024, 1024}, 8'hFF};
        vecs[1] = '{7'd4, 16'sd16384,  1'b1, 8, '{0, 56, 512, 968, 1024, 1024, 1024, 1024}, 8'hFF};
        vecs[2] = '{7'd2, 16'sd16384,  1'b0, 8, '{0, 0, 6, 26, 32, 32, 32, 32}, 8'hFF};
        vecs[3] = '{7'd4, -16'sd16384, 1'b0, 8, '{0, -56, -512, -968, -1024, -1024, -1024, -1024}, 8'hFF};
        vecs[4] = '{7'd8, 16'sd8192,   1'b0, 8, '{0, 0, 0, 0, 0, 16384, 16384, 16384}, 8'hE0};

        rst_n       = 1'b0;
        enable      = 1'b0;
        decim_ratio = 7'd4;
        data        = '0;
        valid       = 1'b0;
        ready_in    = 1'b1;
        repeat (3) tick();
        check("rst_o_valid", out_valid, 0);
        check("rst_o_data", out_data, 0);
        check("rst_o_overrun", overrun, 0);
        check("rst_o_cfg_err", cfg_err, 0);
        check("rst_o_busy", busy, 0);
        check("rst_o_ready", ready_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            start(vecs[i].ratio);
            check($sformatf("vec%0d_ready", i), ready_out, 1);
            stream(vecs[i].n_out * int'(vecs[i].ratio), int'(vecs[i].ratio), vecs[i].din, vecs[i].gapped);
            check($sformatf("vec%0d_count", i), got.size(), vecs[i].n_out);
            for (int j = 0; j < 8; j++) begin
                if (vecs[i].mask[j] && j < got.size())
                    check($sformatf("vec%0d_out%0d", i, j), got[j], vecs[i].exp[j]);
            end
            check($sformatf("vec%0d_overrun", i), overrun, 0);
            check($sformatf("vec%0d_cfg_err", i), cfg_err, 0);
            check($sformatf("vec%0d_busy", i), busy, 0);
        end

        // Backpressure at R=2: results 0, 0, 6 load on edges 3, 5, 7.
        start(7'd2);
        ready_in = 1'b0;
        data     = 16'sd16384;
        for (int t = 1; t <= 7; t++) begin
            valid = (t <= 6);
            tick();
            if (t == 3) begin
                check("bp_valid_1st", out_valid, 1);
                check("bp_overrun_1st", overrun, 0);
            end
            if (t == 5) check("bp_overrun_2nd", overrun, 1);
        end
        check("bp_valid_held", out_valid, 1);
        check("bp_data_latest", out_data, 6);
        ready_in = 1'b1;
        tick();
        check("bp_valid_drop", out_valid, 0);
        check("bp_overrun_sticky", overrun, 1);
        check("bp_busy_idle", busy, 0);

        // Asynchronous reset while a result is pending and the counter is mid-frame.
        start(7'd2);
        ready_in = 1'b0;
        valid    = 1'b1;
        repeat (7) tick();
        check("ar_pre_valid", out_valid, 1);
        check("ar_pre_overrun", overrun, 1);
        check("ar_pre_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_o_valid", out_valid, 0);
        check("ar_o_data", out_data, 0);
        check("ar_o_overrun", overrun, 0);
        check("ar_o_busy", busy, 0);
        valid    = 1'b0;
        enable   = 1'b0;
        ready_in = 1'b1;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        start(7'd4);
        stream(32, 4, 16'sd16384, 1'b0);
        check("ar_restart_count", got.size(), 8);
        for (int j = 0; j < 8; j++) begin
            if (j < got.size()) check($sformatf("ar_restart_out%0d", j), got[j], vecs[0].exp[j]);
        end

        // Ratio clamp and hold.
        start(7'd1);
        tick();
        check("clamp_low_err", cfg_err, 1);
        decim_ratio = 7'd8;
        stream(16, 2, 16'sd16384, 1'b0);
        check("clamp_hold_count", got.size(), 8);
        check("clamp_hold_err", cfg_err, 1);
        start(7'd8);
        stream(16, 8, 16'sd16384, 1'b0);
        check("relatch_count", got.size(), 2);
        check("relatch_err", cfg_err, 0);
        start(7'd100);
        tick();
        check("clamp_high_err", cfg_err, 1);
        start(7'd64);
        tick();
        check("max_ratio_err", cfg_err, 0);

        // Full scale at R=64, positive then negative without a restart.
        start(7'd64);
        stream(512, 64, 16'sd32767, 1'b0);
        check("fs_pos_count", got.size(), 8);
        for (int j = 5; j < 8; j++) begin
            if (j < got.size()) check($sformatf("fs_pos_out%0d", j), got[j], 64'sd2147418112);
        end
        stream(512, 64, -16'sd32768, 1'b0);
        check("fs_neg_count", got.size(), 8);
        for (int j = 6; j < 8; j++) begin
            if (j < got.size()) check($sformatf("fs_neg_out%0d", j), got[j], -64'sd2147483648);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ssemi_cic_decimator.md
Name: ssemi_cic_decimator

Overview:
- Multi-stage CIC (Hogenauer) decimator that takes raw signed ADC samples at the modulator rate.
- Reduces the rate by a programmable ratio R and emits 32-bit signed samples at fs/R.
- Sits directly upstream of the FIR compensation filter and drives its i_data/i_valid.
- Honours the FIR's o_ready as the downstream ready.

Parameters:
IN_WIDTH, 16, signed input sample width
OUT_WIDTH, 32, signed output width (matches FIR INPUT_DATA_WIDTH)
NUM_STAGES, 5, integrator/comb stage count N (legal 1-6)
MAX_DECIM, 64, largest supported ratio (power of 2, legal 4-256)
W_INT, IN_WIDTH+NUM_STAGES*$clog2(MAX_DECIM) (=46), internal register width (derived, not overridable)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_enable  in  1  block enable; low = synchronous clear of all state
i_decim_ratio  in  $clog2(MAX_DECIM)+1 (7)  decimation ratio R, unsigned
i_data  in  IN_WIDTH  signed input sample
i_valid  in  1  input sample valid
o_ready  out  1  ready to accept input (= i_enable)
o_data  out  OUT_WIDTH  signed decimated output
o_valid  out  1  output valid, held until accepted
i_ready  in  1  downstream (FIR) ready
o_overrun  out  1  sticky: unaccepted output was overwritten
o_cfg_err  out  1  latched ratio was out of range and was clamped
o_busy  out  1  an output is pending or the decimation counter is non-zero

Behaviour:
- Reset (async) or i_enable low (sync): all integrators, comb delays, decimation counter and output register cleared. o_data=0, o_valid=0, o_overrun=0, o_cfg_err=0, o_busy=0, o_ready=0.
- Ratio latch: i_decim_ratio captured on the first cycle i_enable is high after being low or after reset. Changes while enabled are ignored.
  - Latched value <2 is clamped to 2; >MAX_DECIM is clamped to MAX_DECIM; either case sets o_cfg_err until disable/reset.
- Accept: a sample is accepted on any cycle with i_valid && o_ready. Nothing changes on cycles without an accept.
- Integrators: on accept, stage 0 += sign-extended i_data and stage k += stage k-1 (registered, ripple of 1 cycle per stage is NOT used; all N updated in the same edge from pre-edge values of the previous stage, stage 0 uses the new input).
  - Two's-complement wrap modulo 2^W_INT is required; no saturation.
- Decimation counter: 0..R-1, increments per accept and wraps to 0. The accept with count==R-1 raises a decimation strobe.
- Comb section: runs on the strobe cycle using the final integrator value. N combs, differential delay M=1.
  - Each stage computes y = x - x_prev and stores x_prev. Combinational chain, wrap arithmetic at W_INT.
- Output scaling: result = (comb_out + 2^(W_INT-OUT_WIDTH-1)) >>> (W_INT-OUT_WIDTH), i.e. round-half-up then arithmetic shift by 14 for the defaults.
  - Gain is R^N, so the output cannot exceed OUT_WIDTH; no saturation logic.
- Latency: o_valid asserts in the 2nd cycle after the edge that accepted the R-th sample (strobe registered, then comb/output registered).
- Output handshake:
  - o_data/o_valid are held stable until o_valid && i_ready, after which o_valid drops next cycle unless a new result loads.
  - New result loading while o_valid=1 and i_ready=0: the new result overwrites, o_valid stays 1, and o_overrun is set sticky.
  - New result in the same cycle the old one is accepted: it loads, no overrun.
- Input is never back-pressured. o_ready does not depend on i_ready.
- First N outputs after enable are transient (comb delays start at 0). Steady state follows.

Test Plan:
- Reset value check: assert i_rst_n low mid-stream with o_valid=1 -> o_valid, o_data, counter and o_overrun all 0 immediately (async). Restart after release matches a fresh run.
- DC at R=4: enable, constant i_data=16384 every cycle, i_ready=1 -> o_valid every 4th cycle; outputs from the 6th onward equal 1024 exactly. First o_valid 2 cycles after the 4th accept.
- Full-scale at R=64: i_data=32767 -> steady output 2147418112. Then i_data=-32768 -> steady output -2147483648. No wrap visible at the output.
- Ratio clamp and hold: i_decim_ratio=1 at enable -> o_cfg_err=1 and outputs every 2 accepts. Changing to 8 while enabled has no effect; toggling i_enable low/high with 8 -> o_cfg_err=0, outputs every 8 accepts.
- Backpressure: R=2, i_ready=0 for 6 accepts -> o_valid held, o_overrun=1 after the 2nd result, and o_data equals the latest result. i_ready=1 -> one transfer, o_valid drops.
- Gapped input: i_valid toggling 1-0 with R=4 -> output appears only after 4 accepts, values identical to the gapless run.
